// File: rtl/usb_cdc_ascii_keyer.sv
// Turns the CDC receive byte stream into paced HID keyboard usage codes.
// Bytes queue in a small FIFO; every emitted key is followed by a fixed idle gap.
module usb_cdc_ascii_keyer #(
  parameter int FIFO_AW    = 4,
  parameter int GAP_CYCLES = 600000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         recv_data,
  input  logic               recv_valid,
  output logic [15:0]        key_value,
  output logic               key_request,
  output logic               overflow,
  output logic [7:0]         drop_count,
  output logic [FIFO_AW:0]   fifo_level
);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, GAP} state_t;

  localparam int          DEPTH    = 1 << FIFO_AW;
  localparam logic [23:0] GAP_INIT = 24'(GAP_CYCLES - 1);

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               full, empty, push, pop;

  state_t             state_q, state_d;
  logic [7:0]         hold_q;
  logic [23:0]        gap_q, gap_d;
  logic [15:0]        key_value_q, key_value_d, code;
  logic               key_request_q, key_request_d, mapped;
  logic               overflow_q;
  logic [7:0]         drop_q;

  assign full    = (level_q == (FIFO_AW+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign push    = recv_valid && !full;
  assign level_d = level_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);

  // ASCII to HID usage; letters ignore case, everything not listed is unmapped
  always_comb begin
    code   = 16'h0000;
    mapped = 1'b0;
    if (hold_q >= 8'h61 && hold_q <= 8'h7A) begin
      mapped = 1'b1;
      code   = {8'h00, hold_q - 8'h5D};
    end else if (hold_q >= 8'h41 && hold_q <= 8'h5A) begin
      mapped = 1'b1;
      code   = {8'h00, hold_q - 8'h3D};
    end else if (hold_q >= 8'h31 && hold_q <= 8'h39) begin
      mapped = 1'b1;
      code   = {8'h00, hold_q - 8'h13};
    end else begin
      case (hold_q)
        8'h30:        begin mapped = 1'b1; code = 16'h0027; end
        8'h0D, 8'h0A: begin mapped = 1'b1; code = 16'h0028; end
        8'h20:        begin mapped = 1'b1; code = 16'h002C; end
        8'h08:        begin mapped = 1'b1; code = 16'h002A; end
        default:      begin mapped = 1'b0; code = 16'h0000; end
      endcase
    end
  end

  // The request pulse is registered on the FETCH->EMIT edge so it is high during EMIT
  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    key_value_d   = key_value_q;
    key_request_d = 1'b0;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (mapped) begin
          key_value_d   = code;
          key_request_d = 1'b1;
          state_d       = EMIT;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        gap_d   = GAP_INIT;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == 24'd0) state_d = IDLE;
        else                gap_d   = gap_q - 24'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= recv_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      state_q       <= IDLE;
      hold_q        <= 8'h00;
      gap_q         <= 24'd0;
      key_value_q   <= 16'h0000;
      key_request_q <= 1'b0;
      overflow_q    <= 1'b0;
      drop_q        <= 8'h00;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        hold_q   <= mem_q[rd_ptr_q];
      end
      level_q       <= level_d;
      state_q       <= state_d;
      gap_q         <= gap_d;
      key_value_q   <= key_value_d;
      key_request_q <= key_request_d;
      overflow_q    <= recv_valid && full;
      if (recv_valid && full && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  assign key_value   = key_value_q;
  assign key_request = key_request_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_usb_cdc_ascii_keyer.sv
// Directed bench for usb_cdc_ascii_keyer: two instances, a short gap (10) and a long gap (1000).
// Expected latencies, codes and drop counts are hand-computed constants.
module tb_usb_cdc_ascii_keyer;

  logic        clk = 1'b0;
  logic        rstA = 1'b1, rstB = 1'b1;
  logic [7:0]  dataA = 8'h00, dataB = 8'h00;
  logic        validA = 1'b0, validB = 1'b0;
  logic [15:0] keyValA, keyValB;
  logic        keyReqA, keyReqB, ovfA, ovfB;
  logic [7:0]  dropA, dropB;
  logic [4:0]  levelA, levelB;

  int cyc = 0;
  int assertCount = 0;
  int failCount = 0;
  int pulseCyc[$];
  int pulseVal[$];
  int pressB = 0, ovfCountB = 0, dblCount = 0;
  logic prevReqA = 1'b0, prevReqB = 1'b0;

  usb_cdc_ascii_keyer #(.FIFO_AW(4), .GAP_CYCLES(10)) dutA (
    .clk(clk), .rst(rstA), .recv_data(dataA), .recv_valid(validA),
    .key_value(keyValA), .key_request(keyReqA), .overflow(ovfA),
    .drop_count(dropA), .fifo_level(levelA)
  );

  usb_cdc_ascii_keyer #(.FIFO_AW(4), .GAP_CYCLES(1000)) dutB (
    .clk(clk), .rst(rstB), .recv_data(dataB), .recv_valid(validB),
    .key_value(keyValB), .key_request(keyReqB), .overflow(ovfB),
    .drop_count(dropB), .fifo_level(levelB)
  );

  // 10 ns clock with a free-running cycle index
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record pulses, overflows and any back-to-back request, sampled mid-cycle
  always @(negedge clk) begin
    if (keyReqA) begin
      pulseCyc.push_back(cyc);
      pulseVal.push_back(int'(keyValA));
    end
    if (keyReqB) pressB++;
    if (ovfB) ovfCountB++;
    if ((keyReqA && prevReqA) || (keyReqB && prevReqB)) dblCount++;
    prevReqA = keyReqA;
    prevReqB = keyReqB;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  // Drives one byte for exactly one cycle; called #1 after a rising edge
  task automatic applyStimulus(input logic [7:0] b, output int t);
    validA = 1'b1;
    dataA  = b;
    t      = cyc;
    @(posedge clk); #1;
    validA = 1'b0;
  endtask

  task automatic applyStimulusB(input logic [7:0] b);
    validB = 1'b1;
    dataB  = b;
    @(posedge clk); #1;
    validB = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int cycAt(input int i);
    return (pulseCyc.size() > i) ? pulseCyc[i] : -1000;
  endfunction

  function automatic int valAt(input int i);
    return (pulseVal.size() > i) ? pulseVal[i] : -1;
  endfunction

  initial begin
    int t, t2, n;

    // Reset state of the short-gap instance
    waitCycles(3);
    rstA = 1'b0;
    checkOutput("reset key_value", int'(keyValA), 0);
    checkOutput("reset key_request", int'(keyReqA), 0);
    checkOutput("reset fifo_level", int'(levelA), 0);
    checkOutput("reset overflow", int'(ovfA), 0);
    checkOutput("reset drop_count", int'(dropA), 0);

    // Single 'a': pulse three cycles after the strobe
    pulseCyc.delete(); pulseVal.delete();
    applyStimulus(8'h61, t);
    waitCycles(10);
    checkOutput("single pulse count", pulseCyc.size(), 1);
    checkOutput("single latency", cycAt(0) - t, 3);
    checkOutput("single code", valAt(0), 'h0004);
    checkOutput("single level", int'(levelA), 0);
    waitCycles(20);

    // Burst "Z9 \r": pulses every GAP_CYCLES+3 = 13 cycles
    pulseCyc.delete(); pulseVal.delete();
    applyStimulus(8'h5A, t);
    applyStimulus(8'h39, t2);
    applyStimulus(8'h20, t2);
    applyStimulus(8'h0D, t2);
    waitCycles(60);
    checkOutput("burst pulse count", pulseCyc.size(), 4);
    checkOutput("burst first latency", cycAt(0) - t, 3);
    checkOutput("burst code Z", valAt(0), 'h001D);
    checkOutput("burst code 9", valAt(1), 'h0026);
    checkOutput("burst code space", valAt(2), 'h002C);
    checkOutput("burst code enter", valAt(3), 'h0028);
    for (int i = 1; i < 4; i++)
      checkOutput($sformatf("burst spacing %0d", i), cycAt(i) - cycAt(i-1), 13);
    waitCycles(20);

    // '!' is discarded without pulse or gap; 'b' pulses at T+5
    pulseCyc.delete(); pulseVal.delete();
    applyStimulus(8'h21, t);
    applyStimulus(8'h62, t2);
    waitCycles(30);
    checkOutput("unmapped pulse count", pulseCyc.size(), 1);
    checkOutput("unmapped then b latency", cycAt(0) - t, 5);
    checkOutput("unmapped then b code", valAt(0), 'h0005);
    waitCycles(10);

    // Reset during GAP with 5 bytes queued
    pulseCyc.delete(); pulseVal.delete();
    for (int i = 0; i < 6; i++) applyStimulus(8'h63, t2);
    checkOutput("pre-reset level", int'(levelA), 5);
    checkOutput("pre-reset pulse count", pulseCyc.size(), 1);
    rstA = 1'b1;
    @(posedge clk); #1;
    rstA = 1'b0;
    checkOutput("mid reset level", int'(levelA), 0);
    checkOutput("mid reset key_value", int'(keyValA), 0);
    checkOutput("mid reset key_request", int'(keyReqA), 0);
    waitCycles(40);
    checkOutput("post reset no pulse", pulseCyc.size(), 1);
    applyStimulus(8'h64, t);
    waitCycles(8);
    checkOutput("post reset pulse count", pulseCyc.size(), 2);
    checkOutput("post reset latency", cycAt(1) - t, 3);
    checkOutput("post reset code", valAt(1), 'h0007);

    // Long-gap instance: 20 'a' back to back, 17 accepted, 3 dropped
    rstB = 1'b0;
    pressB = 0; ovfCountB = 0;
    for (int i = 0; i < 20; i++) applyStimulusB(8'h61);
    waitCycles(2);
    checkOutput("overflow drop_count", int'(dropB), 3);
    checkOutput("overflow pulses", ovfCountB, 3);
    checkOutput("overflow level full", int'(levelB), 16);
    n = 0;
    while (pressB < 17 && n < 20000) begin
      waitCycles(1);
      n++;
    end
    waitCycles(5);
    checkOutput("overflow presses", pressB, 17);
    checkOutput("overflow drained level", int'(levelB), 0);
    checkOutput("overflow last code", int'(keyValB), 'h0004);

    // Saturation: 320 pushes, 17 accepted, 303 overflows, counter holds at 255
    rstB = 1'b1;
    waitCycles(1);
    rstB = 1'b0;
    checkOutput("sat reset drop_count", int'(dropB), 0);
    ovfCountB = 0;
    for (int i = 0; i < 320; i++) applyStimulusB(8'h61);
    waitCycles(2);
    checkOutput("sat drop_count", int'(dropB), 255);
    checkOutput("sat overflow pulses", ovfCountB, 303);

    checkOutput("key_request double-high", dblCount, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
